// File: rtl/reg_file_sb.sv
// Two-write, two-read register file with per-register pending scoreboard.
// Reads, bypass and busy lookups are combinational; all state changes on the rising edge.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  wen0,
  input  logic [ADDR_WIDTH-1:0] waddr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] waddr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  output logic                  busy_any
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pend;
  logic [DEPTH-1:0]      w_pend_next;
  logic                  w_wr0;
  logic                  w_wr1;
  logic                  w_set;
  logic                  w_byp_en;
  logic [ADDR_WIDTH-1:0] w_ra [2];

  // Address 0 is hardwired when ZERO_REG is set: it never stores or goes pending.
  assign w_wr0 = wen0   && !((ZERO_REG != 0) && (waddr0   == '0));
  assign w_wr1 = wen1   && !((ZERO_REG != 0) && (waddr1   == '0));
  assign w_set = set_en && !((ZERO_REG != 0) && (set_addr == '0));

  // Bypass is suppressed while reset is held so every read returns 0.
  assign w_byp_en = (BYPASS != 0) && rstn;

  assign w_ra[0] = raddr1;
  assign w_ra[1] = raddr2;

  // Set is applied after the clears: a new producer supersedes a completing one.
  always_comb begin
    w_pend_next = r_pend;
    if (w_wr0) w_pend_next[waddr0] = 1'b0;
    if (w_wr1) w_pend_next[waddr1] = 1'b0;
    if (w_set) w_pend_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr0) r_regs[waddr0] <= wdata0;
      if (w_wr1) r_regs[waddr1] <= wdata1;
      r_pend <= w_pend_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_WIDTH-1:0] w_rd;
      logic                  w_rb;
      logic                  w_hit0;
      logic                  w_hit1;

      assign w_hit0 = w_wr0 && (waddr0 == w_ra[gi]);
      assign w_hit1 = w_wr1 && (waddr1 == w_ra[gi]);

      always_comb begin
        w_rd = r_regs[w_ra[gi]];
        w_rb = r_pend[w_ra[gi]];
        // Port 1 is the younger result, so it takes priority in the bypass.
        if (w_byp_en && w_hit1) begin
          w_rd = wdata1;
        end else if (w_byp_en && w_hit0) begin
          w_rd = wdata0;
        end
        if (w_byp_en && (w_hit0 || w_hit1) && !(w_set && (set_addr == w_ra[gi]))) begin
          w_rb = 1'b0;
        end
        if ((ZERO_REG != 0) && (w_ra[gi] == '0)) begin
          w_rd = '0;
          w_rb = 1'b0;
        end
      end
    end
  endgenerate

  assign rdata1   = g_rd[0].w_rd;
  assign rdata2   = g_rd[1].w_rd;
  assign rbusy1   = g_rd[0].w_rb;
  assign rbusy2   = g_rd[1].w_rb;
  assign busy_any = |r_pend;

endmodule
